// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle for pwm_multi_channel: run/period/duty-write inputs and PWM outputs.
interface pwm_multi_channel_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
);
    logic             en;
    logic [CNT_W-1:0] period;
    logic             duty_wr;
    logic [CH_W-1:0]  duty_ch;
    logic [CNT_W-1:0] duty_val;
    logic [CH-1:0]    pwm_out;
    logic             period_end;

    modport master (output en, period, duty_wr, duty_ch, duty_val,
                    input  pwm_out, period_end);
    modport slave  (input  en, period, duty_wr, duty_ch, duty_val,
                    output pwm_out, period_end);
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter, per-channel double-buffered duty lanes.
module pwm_multi_channel_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic             wr,
    input  logic [CNT_W-1:0] duty_val,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    logic [CNT_W-1:0] duty_sh, duty_act;

    // Shadow is written regardless of en; the active copy only moves on wrap,
    // so a write landing on the wrap edge is deferred one full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr) duty_sh <= duty_val;
            if (!en) begin
                duty_act <= '0;
                pwm      <= 1'b0;
            end else begin
                pwm <= (cnt < duty_act);
                if (wrap) duty_act <= duty_sh;
            end
        end
    end
endmodule

module pwm_multi_channel #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_multi_channel_if.slave   bus
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic [CNT_W-1:0] cnt, per_act;
    logic             period_end_q;
    logic             wrap;
    logic [CH-1:0]    pwm;

    assign wrap = (cnt == per_act);

    // cnt never passes per_act, so the all-ones period wraps cleanly without overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            per_act      <= '0;
            period_end_q <= 1'b0;
        end else if (!bus.en) begin
            cnt          <= '0;
            per_act      <= '0;
            period_end_q <= 1'b0;
        end else begin
            period_end_q <= wrap;
            if (wrap) begin
                cnt     <= '0;
                per_act <= bus.period;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // An index >= CH matches no lane, so out-of-range writes drop out here.
    for (genvar i = 0; i < CH; i++) begin : g_lane
        logic sel;
        assign sel = bus.duty_wr && (bus.duty_ch == CH_W'(i));

        pwm_multi_channel_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en),
            .wrap     (wrap),
            .wr       (sel),
            .duty_val (bus.duty_val),
            .cnt      (cnt),
            .pwm      (pwm[i])
        );
    end

    assign bus.pwm_out    = pwm;
    assign bus.period_end = period_end_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench: a CH=4 and a CH=5 instance run in lockstep against a period/position model.
module tb_pwm_multi_channel;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] period = '0;
    logic [7:0] val = '0;
    logic       wr_a = 1'b0, wr_b = 1'b0;
    logic [1:0] ch_a = '0;
    logic [2:0] ch_b = '0;

    int vectors = 0;
    int miss = 0;

    pwm_multi_channel_if #(.CH(4), .CNT_W(8)) ifa ();
    pwm_multi_channel_if #(.CH(5), .CNT_W(8)) ifb ();

    assign ifa.en = en;   assign ifa.period = period; assign ifa.duty_val = val;
    assign ifa.duty_wr = wr_a; assign ifa.duty_ch = ch_a;
    assign ifb.en = en;   assign ifb.period = period; assign ifb.duty_val = val;
    assign ifb.duty_wr = wr_b; assign ifb.duty_ch = ch_b;

    pwm_multi_channel #(.CH(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pwm_multi_channel #(.CH(5), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #10 clk = ~clk;

    // Model: position inside the current period, its length, and the duties in force.
    int          nch [2] = '{4, 5};
    int          m_pos [2];
    int          m_len [2];
    int          m_sh  [2][16];
    int          m_act [2][16];
    logic [15:0] m_out [2];
    logic        m_pe  [2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0; m_len[d] = 1; m_out[d] = '0; m_pe[d] = 1'b0;
            for (int i = 0; i < 16; i++) begin m_sh[d][i] = 0; m_act[d][i] = 0; end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit last;
            bit wv;
            int wc;
            if (rst) begin
                m_pos[d] = 0; m_len[d] = 1; m_out[d] = '0; m_pe[d] = 1'b0;
                for (int i = 0; i < 16; i++) begin m_sh[d][i] = 0; m_act[d][i] = 0; end
                continue;
            end
            wv = (d == 0) ? wr_a : wr_b;
            wc = (d == 0) ? int'(ch_a) : int'(ch_b);
            if (en) begin
                last = (m_pos[d] == m_len[d] - 1);
                m_out[d] = '0;
                for (int i = 0; i < nch[d]; i++)
                    m_out[d][i] = (m_pos[d] < imin(m_act[d][i], m_len[d]));
                m_pe[d] = last;
                if (last) begin
                    m_pos[d] = 0;
                    m_len[d] = int'(period) + 1;
                    for (int i = 0; i < 16; i++) m_act[d][i] = m_sh[d][i];
                end else begin
                    m_pos[d]++;
                end
            end else begin
                m_pos[d] = 0; m_len[d] = 1; m_out[d] = '0; m_pe[d] = 1'b0;
                for (int i = 0; i < 16; i++) m_act[d][i] = 0;
            end
            if (wv && wc < nch[d]) m_sh[d][wc] = int'(val);
        end
    endtask

    task automatic check();
        vectors++;
        assert (ifa.pwm_out === m_out[0][3:0]) else begin
            miss++; $error("FAIL pwm_a got %b exp %b t=%0t", ifa.pwm_out, m_out[0][3:0], $time);
        end
        vectors++;
        assert (ifa.period_end === m_pe[0]) else begin
            miss++; $error("FAIL pe_a got %b exp %b t=%0t", ifa.period_end, m_pe[0], $time);
        end
        vectors++;
        assert (ifb.pwm_out === m_out[1][4:0]) else begin
            miss++; $error("FAIL pwm_b got %b exp %b t=%0t", ifb.pwm_out, m_out[1][4:0], $time);
        end
        vectors++;
        assert (ifb.period_end === m_pe[1]) else begin
            miss++; $error("FAIL pe_b got %b exp %b t=%0t", ifb.period_end, m_pe[1], $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wr_duty(input int ch, input int v);
        wr_a = (ch < 4); ch_a = 2'(ch);
        wr_b = (ch < 8); ch_b = 3'(ch);
        val  = 8'(v);
        step();
        wr_a = 1'b0; wr_b = 1'b0;
    endtask

    // Steps until dut_a reports period_end; bounded so a dead counter cannot hang the run.
    task automatic gap(output int n);
        n = 0;
        do begin step(); n++; end while (!ifa.period_end && n < 600);
    endtask

    task automatic count_hi(input int ch, output int h);
        h = 0;
        repeat (8) begin step(); h += int'(ifa.pwm_out[ch]); end
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got == exp) else begin
            miss++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        int n, h;
        model_reset();
        #1 check();
        steps(2);
        rst = 1'b0;

        // 1: period 7, ch0 duty 4 -> 4 high / 4 low, period_end every 8
        period = 8'd7;
        wr_duty(0, 4);
        en = 1'b1;
        gap(n);            expect_int("first_load", n, 1);
        count_hi(0, h);    expect_int("t1_ch0_high", h, 4);
        gap(n);            expect_int("t1_gap", n, 8);

        // 2: duties 0,1,8,255
        wr_duty(0, 0); wr_duty(1, 1); wr_duty(2, 8); wr_duty(3, 255);
        steps(16);
        gap(n);
        count_hi(1, h);    expect_int("t2_ch1_high", h, 1);
        count_hi(2, h);    expect_int("t2_ch2_high", h, 8);
        count_hi(0, h);    expect_int("t2_ch0_high", h, 0);

        // 3: ch1 2->6 mid-period, then a write on the wrap edge
        wr_duty(1, 2);
        gap(n);
        steps(3);
        wr_duty(1, 6);
        gap(n);            expect_int("t3_gap", n, 4);
        count_hi(1, h);    expect_int("t3_ch1_new", h, 6);
        steps(7);
        wr_duty(1, 2);
        count_hi(1, h);    expect_int("t3_wrapwr_deferred", h, 6);
        count_hi(1, h);    expect_int("t3_wrapwr_applied", h, 2);

        // 4: period 7->3 mid-period
        steps(2);
        period = 8'd3;
        gap(n);            expect_int("t4_gap_old", n, 6);
        gap(n);            expect_int("t4_gap_new1", n, 4);
        gap(n);            expect_int("t4_gap_new2", n, 4);

        // 5: out-of-range channel writes on the CH=5 instance
        wr_duty(5, 77);
        wr_duty(7, 1);
        steps(12);

        // 6: async reset mid-period, reload, then en 1->0->1
        period = 8'd7;
        steps(3);
        #5 rst = 1'b1;
        #1 model_reset();
        check();
        steps(2);
        rst = 1'b0;
        wr_duty(0, 3); wr_duty(1, 5); wr_duty(2, 1); wr_duty(3, 9); wr_duty(4, 2);
        steps(20);
        en = 1'b0;
        steps(6);
        en = 1'b1;
        step();
        count_hi(0, h);    expect_int("t6_ch0_held", h, 3);
        count_hi(1, h);    expect_int("t6_ch1_held", h, 5);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 20) begin
                wr_a = 1'b1; wr_b = 1'b1;
                ch_a = 2'($urandom_range(0, 3));
                ch_b = 3'($urandom_range(0, 7));
                val  = 8'($urandom_range(0, 18));
            end
            if ($urandom_range(0, 99) < 2) period = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 1) en = ~en;
            step();
            wr_a = 1'b0; wr_b = 1'b0;
        end

        // Full-width period with maximum duty
        en = 1'b1;
        period = 8'd255;
        wr_duty(0, 255); wr_duty(1, 0); wr_duty(2, 128);
        steps(600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
